// File: rtl/llc_mesi_set_assoc_if.sv
// llc_mesi_set_assoc_if: command, shared-bus, L1 and statistics signals of the LLC tag/state controller
interface llc_mesi_set_assoc_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [1:0]        snoop_in;
    logic [1:0]        snoop_out;
    logic              bus_valid;
    logic [2:0]        bus_op;
    logic [ADDR_W-1:0] bus_addr;
    logic              l1_valid;
    logic [2:0]        l1_msg;
    logic [ADDR_W-1:0] l1_addr;
    logic              done;
    logic [CNT_W-1:0]  n_reads;
    logic [CNT_W-1:0]  n_writes;
    logic [CNT_W-1:0]  n_hits;
    logic [CNT_W-1:0]  n_misses;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, snoop_in,
        input  cmd_ready, snoop_out, bus_valid, bus_op, bus_addr, l1_valid, l1_msg, l1_addr,
        input  done, n_reads, n_writes, n_hits, n_misses
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, snoop_in,
        output cmd_ready, snoop_out, bus_valid, bus_op, bus_addr, l1_valid, l1_msg, l1_addr,
        output done, n_reads, n_writes, n_hits, n_misses
    );
endinterface

// File: rtl/llc_mesi_set_assoc.sv
// llc_mesi_set_assoc: set-associative LLC tag/state controller with MESI lines, tree PLRU and bus/L1 message sequencing
module llc_mesi_set_assoc #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 4,
    parameter int WAYS     = 8,
    parameter int CNT_W    = 16
) (
    input logic                 clock,
    input logic                 reset,
    llc_mesi_set_assoc_if.slave io
);
    localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
    localparam int SETS  = 1 << INDEX_W;
    localparam int WAY_W = $clog2(WAYS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);
    localparam logic [2:0] B_READ = 3'd1, B_WRITE = 3'd2, B_INV = 3'd3, B_RWIM = 3'd4;
    localparam logic [2:0] L_GET = 3'd1, L_SEND = 3'd2, L_INV = 3'd3, L_EVICT = 3'd4;

    typedef enum logic [1:0] {ST_I, ST_S, ST_E, ST_M} mesi_t;
    typedef enum logic [3:0] {
        IDLE, LOOKUP, EV_GET, EV_WR, EV_EVICT, BUS, SN_GET, SN_WR, SN_INV, SEND, CLEAR, DONE
    } state_t;

    state_t             state_q, state_d, miss_next;
    mesi_t              st_q [SETS][WAYS];
    logic [TAG_W-1:0]   tag_q [SETS][WAYS];
    logic [WAYS-2:0]    plru_q [SETS];
    logic [3:0]         op_q;
    logic [ADDR_W-1:0]  addr_q, vaddr_q, line;
    logic [WAY_W-1:0]   way_q, hway, vway;
    logic [2:0]         bop_q;
    logic [1:0]         snp_q;
    logic [INDEX_W-1:0] clr_q, idx;
    logic [TAG_W-1:0]   tag;
    logic [CNT_W-1:0]   rd_q, wr_q, hit_q, miss_q;
    logic               hit, is_cpu, is_wr;
    mesi_t              hst, vst;

    // Victim way of a tree PLRU: each node bit selects the child to evict from (1 = right)
    function automatic logic [WAY_W-1:0] plru_way(input logic [WAYS-2:0] b);
        int n;
        n = 0;
        for (int l = 0; l < WAY_W; l++) n = 2 * n + 1 + int'(b[n]);
        return WAY_W'(n - (WAYS - 1));
    endfunction

    // Make every node on the path to way w point away from it
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] b, input logic [WAY_W-1:0] w);
        logic [WAYS-2:0] r;
        int n;
        r = b;
        n = 0;
        for (int l = WAY_W - 1; l >= 0; l--) begin
            r[n] = ~w[l];
            n = 2 * n + 1 + int'(w[l]);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    assign idx       = addr_q[OFFSET_W +: INDEX_W];
    assign tag       = addr_q[ADDR_W-1 -: TAG_W];
    assign line      = addr_q & LINE_MASK;
    assign is_cpu    = op_q inside {4'd0, 4'd1, 4'd2};
    assign is_wr     = op_q == 4'd1;
    assign hst       = st_q[idx][hway];
    assign vst       = st_q[idx][vway];
    assign miss_next = (vst == ST_M) ? EV_GET : (vst == ST_I) ? BUS : EV_EVICT;

    // Tag compare over the addressed set; victim is the lowest invalid way, else the PLRU way
    always_comb begin
        hit = 1'b0;
        hway = '0;
        vway = plru_way(plru_q[idx]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (st_q[idx][w] != ST_I && tag_q[idx][w] == tag) begin
                hit = 1'b1;
                hway = WAY_W'(w);
            end
            if (st_q[idx][w] == ST_I) vway = WAY_W'(w);
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Next state and one message per cycle; victim messages use the victim line address
    always_comb begin
        state_d = state_q;
        io.bus_valid = 1'b0;
        io.bus_op = 3'd0;
        io.bus_addr = '0;
        io.l1_valid = 1'b0;
        io.l1_msg = 3'd0;
        io.l1_addr = '0;
        case (state_q)
            IDLE: state_d = io.cmd_valid ? LOOKUP : IDLE;
            LOOKUP: case (op_q)
                4'd0, 4'd2: state_d = hit ? SEND : miss_next;
                4'd1: state_d = hit ? ((hst == ST_S) ? BUS : SEND) : miss_next;
                4'd3: state_d = (hit && hst == ST_S) ? SN_INV : DONE;
                4'd4: state_d = (hit && hst == ST_M) ? SN_GET : DONE;
                4'd6: state_d = !hit ? DONE : (hst == ST_M) ? SN_GET : SN_INV;
                4'd8: state_d = CLEAR;
                default: state_d = DONE;
            endcase
            EV_GET: begin
                io.l1_valid = 1'b1;
                io.l1_msg = L_GET;
                io.l1_addr = vaddr_q;
                state_d = EV_WR;
            end
            EV_WR: begin
                io.bus_valid = 1'b1;
                io.bus_op = B_WRITE;
                io.bus_addr = vaddr_q;
                state_d = EV_EVICT;
            end
            EV_EVICT: begin
                io.l1_valid = 1'b1;
                io.l1_msg = L_EVICT;
                io.l1_addr = vaddr_q;
                state_d = BUS;
            end
            BUS: begin
                io.bus_valid = 1'b1;
                io.bus_op = bop_q;
                io.bus_addr = line;
                state_d = SEND;
            end
            SN_GET: begin
                io.l1_valid = 1'b1;
                io.l1_msg = L_GET;
                io.l1_addr = line;
                state_d = SN_WR;
            end
            SN_WR: begin
                io.bus_valid = 1'b1;
                io.bus_op = B_WRITE;
                io.bus_addr = line;
                state_d = (op_q == 4'd6) ? SN_INV : DONE;
            end
            SN_INV: begin
                io.l1_valid = 1'b1;
                io.l1_msg = L_INV;
                io.l1_addr = line;
                state_d = DONE;
            end
            SEND: begin
                io.l1_valid = 1'b1;
                io.l1_msg = L_SEND;
                io.l1_addr = line;
                state_d = DONE;
            end
            CLEAR: state_d = (clr_q == '1) ? DONE : CLEAR;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command latch, MESI/PLRU updates and saturating statistics
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q <= '0;
            addr_q <= '0;
            vaddr_q <= '0;
            way_q <= '0;
            bop_q <= '0;
            snp_q <= '0;
            clr_q <= '0;
            rd_q <= '0;
            wr_q <= '0;
            hit_q <= '0;
            miss_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) st_q[s][w] <= ST_I;
            end
        end else begin
            case (state_q)
                IDLE: if (io.cmd_valid) begin
                    op_q <= io.cmd_op;
                    addr_q <= io.cmd_addr;
                    clr_q <= '0;
                end
                LOOKUP: begin
                    snp_q <= 2'd0;
                    way_q <= hit ? hway : vway;
                    vaddr_q <= {tag_q[idx][vway], idx, {OFFSET_W{1'b0}}};
                    bop_q <= hit ? B_INV : is_wr ? B_RWIM : B_READ;
                    if (is_cpu) begin
                        rd_q <= is_wr ? rd_q : sat(rd_q);
                        wr_q <= is_wr ? sat(wr_q) : wr_q;
                        hit_q <= hit ? sat(hit_q) : hit_q;
                        miss_q <= hit ? miss_q : sat(miss_q);
                        if (hit) plru_q[idx] <= plru_touch(plru_q[idx], hway);
                        if (hit && is_wr && hst != ST_S) st_q[idx][hway] <= ST_M;
                    end
                    if (hit && op_q == 4'd3 && hst == ST_S) begin
                        snp_q <= 2'd1;
                        st_q[idx][hway] <= ST_I;
                    end
                    if (hit && (op_q == 4'd4 || op_q == 4'd6)) begin
                        snp_q <= (hst == ST_M) ? 2'd2 : 2'd1;
                        st_q[idx][hway] <= (op_q == 4'd4) ? ST_S : ST_I;
                    end
                    if (op_q == 4'd8) begin
                        rd_q <= '0;
                        wr_q <= '0;
                        hit_q <= '0;
                        miss_q <= '0;
                    end
                end
                BUS: begin
                    st_q[idx][way_q] <= (bop_q == B_READ) ? ((io.snoop_in == 2'd0) ? ST_E : ST_S) : ST_M;
                    plru_q[idx] <= plru_touch(plru_q[idx], way_q);
                end
                CLEAR: begin
                    plru_q[clr_q] <= '0;
                    for (int w = 0; w < WAYS; w++) st_q[clr_q][w] <= ST_I;
                    clr_q <= clr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Tags carry no meaning while a line is invalid, so they are only written on fill
    always_ff @(posedge clock) begin
        if (state_q == BUS) tag_q[idx][way_q] <= tag;
    end

    assign io.cmd_ready = state_q == IDLE;
    assign io.done      = state_q == DONE;
    assign io.snoop_out = (state_q == DONE) ? snp_q : 2'd0;
    assign io.n_reads   = rd_q;
    assign io.n_writes  = wr_q;
    assign io.n_hits    = hit_q;
    assign io.n_misses  = miss_q;
endmodule

// File: tb/tb_llc_mesi_set_assoc.sv
// tb_llc_mesi_set_assoc: directed scoreboard bench for the LLC MESI controller (narrow counters to reach saturation)
module tb_llc_mesi_set_assoc;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 2;
    localparam logic [2:0] B_READ = 3'd1, B_WRITE = 3'd2, B_INV = 3'd3, B_RWIM = 3'd4;
    localparam logic [2:0] L_GET = 3'd1, L_SEND = 3'd2, L_INV = 3'd3, L_EVICT = 3'd4;
    localparam logic [31:0] A = 32'h0000_1040;

    typedef struct packed {
        logic [1:0]  kind;
        logic [2:0]  code;
        logic [31:0] addr;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    ev_t  exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   e_rd = 0, e_wr = 0, e_hit = 0, e_miss = 0;
    int   cyc;

    always #5 clock = ~clock;

    llc_mesi_set_assoc_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) io ();

    llc_mesi_set_assoc #(
        .ADDR_W(ADDR_W), .OFFSET_W(6), .INDEX_W(4), .WAYS(8), .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io(io)
    );

    function automatic logic [31:0] baddr(input int k);
        return 32'((16 + k) << 10) | 32'h40;
    endfunction

    function automatic logic [31:0] sat(input int x);
        return (x >= (1 << CNT_W) - 1) ? 32'((1 << CNT_W) - 1) : 32'(x);
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] want, input string tag);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [2:0] c, input logic [31:0] a);
        exp_q.push_back('{k, c, a});
    endtask

    task automatic check_ev(input logic [1:0] k, input logic [2:0] c, input logic [31:0] a, input string tag);
        ev_t got;
        ev_t want;
        got = '{k, c, a};
        want = (exp_q.size() != 0) ? exp_q.pop_front() : '{2'd3, 3'd7, 32'hFFFF_FFFF};
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed kind=%0d code=%0d addr=%h expected kind=%0d code=%0d addr=%h",
                   tag, got.kind, got.code, got.addr, want.kind, want.code, want.addr);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            if (io.bus_valid) check_ev(2'd0, io.bus_op, io.bus_addr, "bus");
            if (io.l1_valid) check_ev(2'd1, io.l1_msg, io.l1_addr, "l1");
            if (io.done) begin
                check_ev(2'd2, {1'b0, io.snoop_out}, 32'h0, "done");
                done_cnt++;
            end
        end
    endtask

    task automatic cmd(input logic [3:0] op, input logic [31:0] a, input string tag, output int n);
        int d0;
        int w;
        w = 0;
        @(negedge clock);
        while (!io.cmd_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        chk({31'd0, io.cmd_ready}, 32'd1, {tag, ".ready"});
        io.cmd_valid = 1'b1;
        io.cmd_op = op;
        io.cmd_addr = a;
        d0 = done_cnt;
        @(posedge clock);
        #1;
        io.cmd_valid = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(posedge clock);
            #2;
            n++;
        end
        chk({31'd0, done_cnt != d0}, 32'd1, {tag, ".done_seen"});
        chk(32'(exp_q.size()), 32'd0, {tag, ".pending"});
    endtask

    task automatic check_cnt(input string tag);
        chk(32'(io.n_reads), sat(e_rd), {tag, ".n_reads"});
        chk(32'(io.n_writes), sat(e_wr), {tag, ".n_writes"});
        chk(32'(io.n_hits), sat(e_hit), {tag, ".n_hits"});
        chk(32'(io.n_misses), sat(e_miss), {tag, ".n_misses"});
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        io.cmd_valid = 1'b0;
        io.cmd_op = 4'd0;
        io.cmd_addr = '0;
        io.snoop_in = 2'd0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk({31'd0, io.cmd_ready}, 32'd1, "reset.ready");
        chk({29'd0, io.bus_valid, io.l1_valid, io.done}, 32'd0, "reset.pulses");
        check_cnt("reset");
        reset = 1'b0;

        // cold read miss with NOHIT -> E
        push(2'd0, B_READ, A);
        push(2'd1, L_SEND, A);
        push(2'd2, 3'd0, 0);
        cmd(4'd0, A, "rd_miss", cyc);
        e_rd++;
        e_miss++;
        check_cnt("rd_miss");

        // read hit, then write hit on E: no bus op
        push(2'd1, L_SEND, A);
        push(2'd2, 3'd0, 0);
        cmd(4'd0, A, "rd_hit", cyc);
        e_rd++;
        e_hit++;
        push(2'd1, L_SEND, A);
        push(2'd2, 3'd0, 0);
        cmd(4'd1, A, "wr_hit_e", cyc);
        e_wr++;
        e_hit++;
        check_cnt("hits");

        // snoop READ on M -> HITM, GETLINE, WRITE, S; RWIM on S -> HIT, INVALIDATELINE; INVALIDATE on I -> NOHIT
        push(2'd1, L_GET, A);
        push(2'd0, B_WRITE, A);
        push(2'd2, 3'd2, 0);
        cmd(4'd4, A, "snp_rd_m", cyc);
        push(2'd1, L_INV, A);
        push(2'd2, 3'd1, 0);
        cmd(4'd6, A, "snp_rwim_s", cyc);
        push(2'd2, 3'd0, 0);
        cmd(4'd3, A, "snp_inv_i", cyc);
        check_cnt("snoops");

        // snoop_in=3 behaves as HITM -> S; write on S -> INVALIDATE -> M
        io.snoop_in = 2'd3;
        push(2'd0, B_READ, A);
        push(2'd1, L_SEND, A);
        push(2'd2, 3'd0, 0);
        cmd(4'd0, A, "rd_miss_hitm", cyc);
        e_rd++;
        e_miss++;
        io.snoop_in = 2'd0;
        push(2'd0, B_INV, A);
        push(2'd1, L_SEND, A);
        push(2'd2, 3'd0, 0);
        cmd(4'd1, A, "wr_hit_s", cyc);
        e_wr++;
        e_hit++;
        push(2'd1, L_GET, A);
        push(2'd0, B_WRITE, A);
        push(2'd2, 3'd2, 0);
        cmd(4'd4, A, "snp_rd_m2", cyc);
        push(2'd2, 3'd1, 0);
        cmd(4'd4, A, "snp_rd_s", cyc);
        push(2'd1, L_INV, A);
        push(2'd2, 3'd1, 0);
        cmd(4'd3, A, "snp_inv_s", cyc);
        push(2'd2, 3'd0, 0);
        cmd(4'd3, A, "snp_inv_i2", cyc);
        push(2'd2, 3'd0, 0);
        cmd(4'd5, A, "snp_write", cyc);
        push(2'd2, 3'd0, 0);
        cmd(4'd7, A, "unknown", cyc);
        push(2'd2, 3'd0, 0);
        cmd(4'd9, A, "print", cyc);
        check_cnt("mid");

        // fill set 1 with 8 M lines; sequential fills leave PLRU pointing at way 0
        for (int k = 0; k < 8; k++) begin
            push(2'd0, B_RWIM, baddr(k));
            push(2'd1, L_SEND, baddr(k));
            push(2'd2, 3'd0, 0);
            cmd(4'd1, baddr(k), "fill", cyc);
            e_wr++;
            e_miss++;
        end
        push(2'd1, L_GET, baddr(0));
        push(2'd0, B_WRITE, baddr(0));
        push(2'd1, L_EVICT, baddr(0));
        push(2'd0, B_RWIM, baddr(8));
        push(2'd1, L_SEND, baddr(8));
        push(2'd2, 3'd0, 0);
        cmd(4'd1, baddr(8), "evict_way0", cyc);
        e_wr++;
        e_miss++;
        // after touching way 0 again, PLRU selects way 4
        push(2'd1, L_GET, baddr(4));
        push(2'd0, B_WRITE, baddr(4));
        push(2'd1, L_EVICT, baddr(4));
        push(2'd0, B_READ, baddr(0));
        push(2'd1, L_SEND, baddr(0));
        push(2'd2, 3'd0, 0);
        cmd(4'd0, baddr(0), "evict_way4", cyc);
        e_rd++;
        e_miss++;
        check_cnt("saturated");

        // clear: all sets walked, counters zeroed, lines invalid
        push(2'd2, 3'd0, 0);
        cmd(4'd8, 32'h0, "clear", cyc);
        chk({31'd0, cyc > 16}, 32'd1, "clear.cycles");
        e_rd = 0;
        e_wr = 0;
        e_hit = 0;
        e_miss = 0;
        check_cnt("clear");
        push(2'd0, B_READ, baddr(1));
        push(2'd1, L_SEND, baddr(1));
        push(2'd2, 3'd0, 0);
        cmd(4'd0, baddr(1), "rd_after_clear", cyc);
        e_rd++;
        e_miss++;
        check_cnt("after_clear");

        // reset during a miss: nothing further may appear
        @(negedge clock);
        io.cmd_valid = 1'b1;
        io.cmd_op = 4'd0;
        io.cmd_addr = baddr(2);
        @(posedge clock);
        #1;
        io.cmd_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        e_rd = 0;
        e_miss = 0;
        chk({31'd0, io.cmd_ready}, 32'd1, "abort.ready");
        chk(32'(exp_q.size()), 32'd0, "abort.pending");
        check_cnt("abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
